// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 key event controller: prefix bytes,
// parse-state encoding and the packed event record stored in the FIFO.
package kbd_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parse_state_t;

    typedef struct packed {
        logic       ext;
        logic       press;
        logic [7:0] code;
    } key_event_t;

    localparam int EVENT_W = $bits(key_event_t);

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous ready/valid FIFO. Pointers carry an extra wrap bit so that
// full and valid can be registered from the next-pointer values. A push is
// accepted while full if the head is popped in the same cycle.
module key_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_n, rd_ptr_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr, do_rd;

    assign in_ready = ~full | out_ready;
    assign do_wr    = in_valid & in_ready;
    assign do_rd    = out_valid & out_ready;
    assign wr_ptr_n = wr_ptr + (AW+1)'(do_wr);
    assign rd_ptr_n = rd_ptr + (AW+1)'(do_rd);

    // Head data is forced to zero while empty so the outputs read 0 out of reset.
    assign out_data = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // Pointer advance and registered full/valid flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            full      <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                         (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            out_valid <= (wr_ptr_n != rd_ptr_n);
        end
    end

    // Storage array write; contents need no reset since valid gates the output.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event controller: drains scan-code bytes from the receiver,
// decodes E0/F0 prefixes into one event per key transition, filters
// typematic repeats of the held key and queues events for a consumer.
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, waiting for code or F0
// ST_BRK     | F0 seen, waiting for break code
// ST_EXT_BRK | E0 F0 seen, waiting for extended break code
module ps2_key_event_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int COUNT_W       = 8,
    parameter int FILTER_REPEAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         ps2_data,
    input  logic               ps2_ready,
    input  logic               ps2_overflow,
    output logic               ps2_nextdata_n,
    input  logic               err_clr,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [7:0]         ev_code,
    output logic               ev_ext,
    output logic               ev_press,
    output logic               key_down,
    output logic [COUNT_W-1:0] press_count,
    output logic               fifo_full,
    output logic               err_sticky
);

    parse_state_t state_q, state_n;
    logic [7:0]   byte_q;
    logic         byte_vld;
    logic         emit, emit_ext, emit_press, parse_err;
    logic [7:0]   held_code;
    logic         held_ext, held_valid, held_match;
    logic         suppress, push, push_ok, drop, fifo_in_ready;
    key_event_t   push_ev, head_ev;

    // The acknowledge pulse doubles as the "byte waiting to be parsed" flag.
    assign byte_vld = ~ps2_nextdata_n;

    // Byte intake: latch one byte and pulse the acknowledge low for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_nextdata_n <= 1'b1;
            byte_q         <= 8'h00;
        end else if (ps2_nextdata_n && ps2_ready) begin
            ps2_nextdata_n <= 1'b0;
            byte_q         <= ps2_data;
        end else begin
            ps2_nextdata_n <= 1'b1;
        end
    end

    // Parse state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Prefix decoding; a stray prefix after F0 is flagged and reparsed from idle.
    always_comb begin
        state_n    = state_q;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_press = 1'b1;
        parse_err  = 1'b0;
        if (ps2_overflow) begin
            state_n = ST_IDLE;
        end else if (byte_vld && byte_q != 8'h00) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == PS2_EXT)      state_n = ST_EXT;
                    else if (byte_q == PS2_BRK) state_n = ST_BRK;
                    else                        emit = 1'b1;
                end
                ST_EXT: begin
                    if (byte_q == PS2_BRK) begin
                        state_n = ST_EXT_BRK;
                    end else if (byte_q == PS2_EXT) begin
                        parse_err = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (byte_q == PS2_EXT || byte_q == PS2_BRK) begin
                        parse_err = 1'b1;
                        state_n   = (byte_q == PS2_EXT) ? ST_EXT : ST_BRK;
                    end else begin
                        emit       = 1'b1;
                        emit_ext   = (state_q == ST_EXT_BRK);
                        emit_press = 1'b0;
                        state_n    = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign held_match = held_valid && (held_code == byte_q) && (held_ext == emit_ext);
    assign suppress   = (FILTER_REPEAT != 0) && emit && emit_press && held_match;
    assign push       = emit && !suppress;
    assign push_ok    = push && fifo_in_ready;
    assign drop       = push && !fifo_in_ready;
    assign push_ev    = {emit_ext, emit_press, byte_q};

    // Held-key tracker; dropped events still update it so key_down follows the keyboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_code  <= 8'h00;
            held_ext   <= 1'b0;
            held_valid <= 1'b0;
        end else if (push) begin
            if (emit_press) begin
                held_code  <= byte_q;
                held_ext   <= emit_ext;
                held_valid <= 1'b1;
            end else if (held_match) begin
                held_valid <= 1'b0;
            end
        end
    end

    // Count makes that actually reach the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_count <= '0;
        end else if (push_ok && emit_press) begin
            press_count <= press_count + COUNT_W'(1);
        end
    end

    // Sticky error: a new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (parse_err || ps2_overflow || drop) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    key_event_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_ready  (fifo_in_ready),
        .in_data   (push_ev),
        .out_valid (ev_valid),
        .out_ready (ev_ready),
        .out_data  (head_ev),
        .full      (fifo_full)
    );

    assign ev_code  = head_ev.code;
    assign ev_ext   = head_ev.ext;
    assign ev_press = head_ev.press;
    assign key_down = held_valid;

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Parametrised PS/2 keyboard event controller. It sits between the PS/2 byte receiver (ps2_keyboard) and system consumers such as display, CPU MMIO or the game logic. It drains scan-code bytes with the nextdata_n handshake and decodes make/break and the E0-extended prefixes into one event per key transition. Events are buffered in a ready/valid FIFO; the block also suppresses typematic repeats and maintains press statistics and error flags.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of 2, ≥2
- COUNT_W, 8: press counter width
- FILTER_REPEAT, 1: 1 = drop auto-repeat makes of the currently held key
- clk  in  1  system clock; the only clock
- rst  in  1  reset; asynchronous, active-high
- ps2_data  in  8  byte from receiver, valid while ps2_ready=1
- ps2_ready  in  1  receiver has a byte
- ps2_overflow  in  1  receiver FIFO overflowed
- ps2_nextdata_n  out  1  active-low one-cycle byte acknowledge
- err_clr  in  1  clears err_sticky
- ev_valid  out  1  event available at FIFO head
- ev_ready  in  1  consumer accepts head event
- ev_code  out  8  scan code, with prefixes stripped
- ev_ext  out  1  code was E0-prefixed
- ev_press  out  1  1 = make, 0 = break
- key_down  out  1  a held (made, not yet broken) key is tracked
- press_count  out  COUNT_W  accepted make events, modulo 2^COUNT_W
- fifo_full  out  1  FIFO holds FIFO_DEPTH events
- err_sticky  out  1  protocol error, overflow or dropped event since last clear

## Operation
Byte intake:
- A byte is consumed on a clock edge where ps2_ready=1 and ps2_nextdata_n=1.
- ps2_nextdata_n goes low for exactly the following cycle, then returns high.
- No byte is consumed while ps2_nextdata_n=0.
- Byte 0x00 is acknowledged and discarded.

Parse FSM, states IDLE, EXT, BRK, EXT_BRK:
- IDLE: E0→EXT; F0→BRK; other byte→emit (ext=0, press=1).
- EXT: F0→EXT_BRK; E0→stay in EXT and set err; other byte→emit (ext=1, press=1), →IDLE.
- BRK: other byte→emit (ext=0, press=0), →IDLE; E0/F0→set err, then reparse that byte from IDLE.
- EXT_BRK: other byte→emit (ext=1, press=0), →IDLE; E0/F0→set err, then reparse from IDLE.

Held-key tracker, fields held_code, held_ext, held_valid:
- A make with FILTER_REPEAT=1, held_valid=1 and a matching code/ext is suppressed: no push, no count.
- Any other make loads the tracker and sets held_valid.
- A break that matches the tracker clears held_valid; a non-matching break leaves the tracker unchanged.
- key_down equals held_valid.

Event push:
- Every non-suppressed emit pushes one event.
- press_count increments on each pushed make; it wraps to 0.
- An emit while the FIFO is full and not popping in the same cycle drops the event and sets err. A dropped make does not count but still updates the tracker.
- Push and pop in the same cycle while full: no drop; occupancy is unchanged.

Errors:
- ps2_overflow=1 in any cycle forces FSM→IDLE and sets err. The FIFO and tracker are kept.
- err_clr clears err_sticky. A new err in the same cycle wins, so the flag stays 1.

## Timing
- Reset values:
  - ps2_nextdata_n=1, ev_valid=0, fifo_full=0, key_down=0, err_sticky=0
  - press_count=0, FSM=IDLE
  - ev_code, ev_ext and ev_press = 0
- Latency: the final byte of a sequence is consumed at edge E. The event is written at edge E+1. ev_valid=1 from E+1.
- Maximum intake is one byte per 2 cycles.
- ev_code, ev_ext and ev_press are stable while ev_valid=1 and ev_ready=0.
- A pop occurs on an edge with ev_valid & ev_ready.
- fifo_full and ev_valid are registered, derived from pointers with an extra wrap bit.
- Reset asserted mid-sequence discards the partial prefix and empties the FIFO immediately.

## Structure
- Shared package kbd_pkg holds:
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0
  - the parse-state enum
  - the packed event typedef {ext, press, code[7:0]}
- One sub-module, key_event_fifo: a synchronous FIFO parameterised by width and depth, with ready/valid ports and a full flag.
- The parse FSM, tracker and counters live in the top module.

## Test plan
- Bytes 1C, F0 1C → events (1C, ext0, press1), then (1C, ext0, press0); press_count=1; key_down 1→0.
- Bytes E0 75, E0 F0 75 → events (75, ext1, press1), then (75, ext1, press0); err_sticky=0.
- Bytes 1C ×5, F0 1C with FILTER_REPEAT=1 → exactly 2 events, press_count=1. With FILTER_REPEAT=0 → 6 events, press_count=5.
- ev_ready=0, 9 makes of distinct codes, FIFO_DEPTH=8 → fifo_full=1, 8 events retained, err_sticky=1, press_count=8. Then pop all → codes in order.
- Bytes E0 then ps2_overflow pulse, then 1C → event (1C, ext0) and err_sticky=1. err_clr → 0.
- Bytes F0 E0 75 → err set; event (75, ext1, press1). rst asserted mid-sequence → all outputs at reset values within the same cycle.
